// File: rtl/hamming_disp_scan_if.sv
// Bus bundle for hamming_disp_scan: load/clear controls in, multiplexed display and count out.
interface hamming_disp_scan_if;
  logic       load;
  logic [3:0] data_in;
  logic [2:0] pos_err;
  logic       clr_cnt;
  logic [6:0] segments;
  logic [3:0] anodes;
  logic [7:0] err_cnt;

  modport master (
    output load, data_in, pos_err, clr_cnt,
    input  segments, anodes, err_cnt
  );

  modport slave (
    input  load, data_in, pos_err, clr_cnt,
    output segments, anodes, err_cnt
  );
endinterface

// File: rtl/hamming_disp_scan.sv
// Multiplexed 4-digit seven-segment driver for Hamming(7,4) decode results with error counter.
// Optional macro ERR_BLINK_EN blinks the syndrome digit while a nonzero syndrome is latched.
module hamming_disp_scan #(
  parameter int unsigned REFRESH_DIV  = 50000,
  parameter int unsigned BLINK_CYCLES = 25000000
) (
  input logic              clk,
  input logic              rst,
  hamming_disp_scan_if.slave bus
);

  if (REFRESH_DIV < 2) begin : gBadRefresh
    $error("REFRESH_DIV must be at least 2");
  end
  if (BLINK_CYCLES < 2) begin : gBadBlink
    $error("BLINK_CYCLES must be at least 2");
  end

  localparam int unsigned PrescW = $clog2(REFRESH_DIV);
  localparam logic [PrescW-1:0] PrescLast = PrescW'(REFRESH_DIV - 1);

  logic [PrescW-1:0] prescQ, prescD;
  logic [1:0]        digitQ, digitD;
  logic [3:0]        dataQ, dataD;
  logic [2:0]        synQ, synD;
  logic              loadedQ, loadedD;
  logic [7:0]        cntQ, cntD;
  logic [6:0]        segQ, segD;
  logic [3:0]        anQ, anD;
  logic [3:0]        nibble;
  logic              blankDig1;

  function automatic logic [6:0] hexGlyph(input logic [3:0] v);
    logic [6:0] g;
    g = 7'h7F;
    case (v)
      4'h0: g = 7'h40;
      4'h1: g = 7'h79;
      4'h2: g = 7'h24;
      4'h3: g = 7'h30;
      4'h4: g = 7'h19;
      4'h5: g = 7'h12;
      4'h6: g = 7'h02;
      4'h7: g = 7'h78;
      4'h8: g = 7'h00;
      4'h9: g = 7'h10;
      4'hA: g = 7'h08;
      4'hB: g = 7'h03;
      4'hC: g = 7'h46;
      4'hD: g = 7'h21;
      4'hE: g = 7'h06;
      4'hF: g = 7'h0E;
      default: g = 7'h7F;
    endcase
    return g;
  endfunction

`ifdef ERR_BLINK_EN
  localparam int unsigned BlinkW = $clog2(BLINK_CYCLES);
  localparam logic [BlinkW-1:0] BlinkLast = BlinkW'(BLINK_CYCLES - 1);

  typedef enum logic {StShow, StBlank} blinkStateE;

  blinkStateE        blinkStateQ, blinkStateD;
  logic [BlinkW-1:0] blinkCntQ, blinkCntD;

  // Any load restarts the blink phase; a zero syndrome parks the FSM in SHOW.
  always_comb begin
    blinkStateD = blinkStateQ;
    blinkCntD   = blinkCntQ;
    if (bus.load || (synQ == 3'd0)) begin
      blinkStateD = StShow;
      blinkCntD   = '0;
    end else if (blinkCntQ == BlinkLast) begin
      blinkCntD   = '0;
      blinkStateD = (blinkStateQ == StShow) ? StBlank : StShow;
    end else begin
      blinkCntD = blinkCntQ + BlinkW'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      blinkStateQ <= StShow;
      blinkCntQ   <= '0;
    end else begin
      blinkStateQ <= blinkStateD;
      blinkCntQ   <= blinkCntD;
    end
  end

  assign blankDig1 = (blinkStateQ == StBlank);
`else
  assign blankDig1 = 1'b0;
`endif

  always_comb begin
    prescD = prescQ + PrescW'(1);
    digitD = digitQ;
    if (prescQ == PrescLast) begin
      prescD = '0;
      digitD = digitQ + 2'd1;
    end

    dataD   = dataQ;
    synD    = synQ;
    loadedD = loadedQ;
    if (bus.load) begin
      dataD   = bus.data_in;
      synD    = bus.pos_err;
      loadedD = 1'b1;
    end

    // Clear has priority over a same-cycle error load; data still captured above.
    cntD = cntQ;
    if (bus.clr_cnt) begin
      cntD = 8'h00;
    end else if (bus.load && (bus.pos_err != 3'd0) && (cntQ != 8'hFF)) begin
      cntD = cntQ + 8'd1;
    end

    nibble = 4'h0;
    unique case (digitQ)
      2'd0: nibble = dataQ;
      2'd1: nibble = {1'b0, synQ};
      2'd2: nibble = cntQ[3:0];
      2'd3: nibble = cntQ[7:4];
    endcase

    // Glyph and anode are registered together so they always switch on the same edge.
    anD  = ~(4'b0001 << digitQ);
    segD = hexGlyph(nibble);
    if (!loadedQ || ((digitQ == 2'd1) && blankDig1)) begin
      segD = 7'h7F;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      prescQ  <= '0;
      digitQ  <= 2'd0;
      dataQ   <= 4'h0;
      synQ    <= 3'd0;
      loadedQ <= 1'b0;
      cntQ    <= 8'h00;
      segQ    <= 7'h7F;
      anQ     <= 4'hF;
    end else begin
      prescQ  <= prescD;
      digitQ  <= digitD;
      dataQ   <= dataD;
      synQ    <= synD;
      loadedQ <= loadedD;
      cntQ    <= cntD;
      segQ    <= segD;
      anQ     <= anD;
    end
  end

  assign bus.segments = segQ;
  assign bus.anodes   = anQ;
  assign bus.err_cnt  = cntQ;

endmodule

// File: tb/tb_hamming_disp_scan.sv
// Self-checking bench for hamming_disp_scan: vector table, corner sequences and random stimulus
// compared against a cycle-count based reference model.
module tb_hamming_disp_scan;
  localparam int unsigned RefreshDiv  = 4;
  localparam int unsigned BlinkCycles = 16;
`ifdef ERR_BLINK_EN
  localparam bit BlinkOn = 1'b1;
`else
  localparam bit BlinkOn = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst = 1'b1;
  hamming_disp_scan_if bus();

  hamming_disp_scan #(
    .REFRESH_DIV (RefreshDiv),
    .BLINK_CYCLES(BlinkCycles)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  logic [6:0] hexTab [16] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
                              7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E};

  // Reference model: edges since reset release, latched values, edges since last load.
  int         k;
  bit         mLoaded;
  logic [3:0] mData;
  logic [2:0] mSyn;
  int         mCnt;
  int         mSinceLoad;
  int         curDig;

  typedef struct {
    bit         ld;
    logic [3:0] d;
    logic [2:0] s;
    bit         clr;
    logic [7:0] expCnt;
    logic [6:0] expD1;
    logic [6:0] expD2;
  } vec_t;
  vec_t vecs [5];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic bit blankNow();
    return BlinkOn && (mSyn != 3'd0) && (((mSinceLoad / BlinkCycles) % 2) == 1);
  endfunction

  task automatic step(input bit ld, input logic [3:0] d, input logic [2:0] s, input bit clr,
                      input bit r);
    logic [6:0] expSeg;
    logic [3:0] expAn;
    int v;
    bus.load    = ld;
    bus.data_in = d;
    bus.pos_err = s;
    bus.clr_cnt = clr;
    rst         = r;
    @(posedge clk);
    if (r) begin
      expSeg = 7'h7F;
      expAn  = 4'hF;
      k = 0; mLoaded = 0; mData = 0; mSyn = 0; mCnt = 0; mSinceLoad = 0; curDig = -1;
    end else begin
      k++;
      curDig = ((k - 1) / RefreshDiv) % 4;
      expAn  = 4'hF & ~(4'b0001 << curDig);
      case (curDig)
        0:       v = mData;
        1:       v = mSyn;
        2:       v = mCnt % 16;
        default: v = mCnt / 16;
      endcase
      if (!mLoaded || (curDig == 1 && blankNow())) expSeg = 7'h7F;
      else expSeg = hexTab[v];
      if (ld) begin
        mData = d; mSyn = s; mLoaded = 1; mSinceLoad = 0;
      end else begin
        mSinceLoad++;
      end
      if (clr) mCnt = 0;
      else if (ld && s != 0 && mCnt < 255) mCnt++;
    end
    #1;
    check("anodes", 32'(bus.anodes), 32'(expAn));
    check("segments", 32'(bus.segments), 32'(expSeg));
    check("err_cnt", 32'(bus.err_cnt), 32'(mCnt));
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(0, 4'h0, 3'd0, 0, 0);
  endtask

  initial begin
    int sawBlank;
    int sawGlyph;
    vecs[0] = '{1, 4'h5, 3'd3, 0, 8'd1, 7'h30, 7'h79};
    vecs[1] = '{1, 4'h5, 3'd1, 0, 8'd2, 7'h79, 7'h24};
    vecs[2] = '{1, 4'hA, 3'd0, 0, 8'd2, 7'h40, 7'h24};
    vecs[3] = '{1, 4'h2, 3'd7, 1, 8'd0, 7'h78, 7'h40};
    vecs[4] = '{1, 4'hF, 3'd4, 0, 8'd1, 7'h19, 7'h79};

    bus.load = 0; bus.data_in = 0; bus.pos_err = 0; bus.clr_cnt = 0;

    // Reset and idle scan: blank segments, rotating anodes.
    step(0, 4'h0, 3'd0, 0, 1);
    step(0, 4'h0, 3'd0, 0, 1);
    check("rst_anodes", 32'(bus.anodes), 32'h0000000F);
    check("rst_segments", 32'(bus.segments), 32'h0000007F);
    step(0, 4'h0, 3'd0, 0, 0);
    check("first_anode", 32'(bus.anodes), 32'h0000000E);
    idle(19);

    // Error-free load: 5 on digit 0, zeros elsewhere.
    step(1, 4'h5, 3'd0, 0, 0);
    for (int i = 0; i < 16; i++) begin
      step(0, 4'h0, 3'd0, 0, 0);
      check("load5_glyph", 32'(bus.segments), (curDig == 0) ? 32'h12 : 32'h40);
    end

    // Vector table: counts, syndrome glyph and low count glyph after each load.
    for (int j = 0; j < 5; j++) begin
      step(vecs[j].ld, vecs[j].d, vecs[j].s, vecs[j].clr, 0);
      check("vec_cnt", 32'(bus.err_cnt), 32'(vecs[j].expCnt));
      for (int i = 0; i < 16; i++) begin
        step(0, 4'h0, 3'd0, 0, 0);
        if (curDig == 1) check("vec_dig1", 32'(bus.segments), 32'(vecs[j].expD1));
        if (curDig == 2) check("vec_dig2", 32'(bus.segments), 32'(vecs[j].expD2));
      end
    end

    // Saturation.
    step(0, 4'h0, 3'd0, 1, 0);
    for (int i = 0; i < 300; i++) step(1, 4'($urandom), 3'($urandom_range(7, 1)), 0, 0);
    check("sat_cnt", 32'(bus.err_cnt), 32'h000000FF);
    for (int i = 0; i < 16; i++) begin
      step(0, 4'h0, 3'd0, 0, 0);
      if (curDig >= 2) check("sat_glyph", 32'(bus.segments), 32'h0000000E);
    end

    // Blink on syndrome 6, then stop after a clean load.
    step(1, 4'h0, 3'd6, 0, 0);
    sawBlank = 0;
    sawGlyph = 0;
    for (int i = 0; i < 80; i++) begin
      step(0, 4'h0, 3'd0, 0, 0);
      if (curDig == 1 && bus.segments == 7'h7F) sawBlank++;
      if (curDig == 1 && bus.segments == 7'h02) sawGlyph++;
    end
    check("blink_glyph_seen", 32'(sawGlyph > 0), 32'd1);
`ifdef ERR_BLINK_EN
    check("blink_blank_seen", 32'(sawBlank > 0), 32'd1);
`else
    check("no_blink", 32'(sawBlank), 32'd0);
`endif
    step(1, 4'h3, 3'd0, 0, 0);
    sawBlank = 0;
    for (int i = 0; i < 64; i++) begin
      step(0, 4'h0, 3'd0, 0, 0);
      if (curDig == 1 && bus.segments == 7'h7F) sawBlank++;
    end
    check("blink_stopped", 32'(sawBlank), 32'd0);

    // Random traffic with occasional mid-scan resets.
    for (int i = 0; i < 600; i++) begin
      step($urandom_range(3) == 0, 4'($urandom), 3'($urandom), $urandom_range(15) == 0,
           $urandom_range(149) == 0);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
